z80_bus_initiator: RTL
======================

Z80_BUS_INITIATOR -- requirements
Module: z80_bus_initiator

Interface
REQ-001 Parameter MEM_WAIT, default 0: wait states inserted in memory cycles, range 0-7.
REQ-002 Parameter IO_WAIT, default 1: wait states inserted in I/O cycles, range 0-7.
REQ-003 mck  in  1  single clock; all logic on posedge mck.
REQ-004 rin  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_io  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-008 cmd_wr  in  1  1 = write, 0 = read.
REQ-009 cmd_m1  in  1  memory read is an opcode fetch; ignored otherwise.
REQ-010 cmd_halt  in  1  halt command; has priority over cmd_io, cmd_wr and cmd_m1.
REQ-011 cmd_addr  in  16  bus address.
REQ-012 cmd_wdata  in  8  write data.
REQ-013 rsp_valid  out  1  one-cycle completion pulse.
REQ-014 rsp_rdata  out  8  read data, valid with rsp_valid.
REQ-015 wake  in  1  halt exit request.
REQ-016 ca  out  16  Z80 address bus.
REQ-017 cdo  out  8  data driven toward the Blink.
REQ-018 cdi  in  8  data returned by the Blink.
REQ-019 mrq_n, ior_n, crd_n, cm1_n, hlt_n  out  1 each  bus strobes, active low.

Function
REQ-020 FSM states: IDLE, T1, T2, TW, T3, HALT; cmd_ready = 1 only in IDLE.
REQ-021 On accept in IDLE, the command is latched and the next state is T1.
REQ-022 T1: ca = latched address; all strobes high; cm1_n low if memory read with cmd_m1.
REQ-023 T2, TW, T3: mrq_n low (memory) or ior_n low (I/O); cm1_n stays low for an M1 fetch.
REQ-024 crd_n encoding: memory read 0, memory write 1, I/O write 0, I/O read 1.
REQ-025 TW repeats MEM_WAIT or IO_WAIT times and is skipped when the count is 0.
REQ-026 cdo = latched wdata from T1 through T3 of write cycles, 8'h00 otherwise.
REQ-027 Reads sample cdi at the posedge ending T3 into rsp_rdata; rsp_rdata holds its value until the next read completes.
REQ-028 After T3: next state IDLE, rsp_valid = 1 for exactly that IDLE cycle, all strobes high.
REQ-029 Latency from accept edge to rsp_valid: 4 + wait-count cycles.
REQ-030 A new command may be accepted in the rsp_valid cycle, giving back-to-back cycles with no idle gap.
REQ-031 ca holds the last driven address while in IDLE.
REQ-032 cmd_* inputs are ignored outside the accept cycle.
REQ-033 The wait counter is 3 bits, loads at T2 and decrements in TW.

Reset
REQ-034 rin = 1 at a posedge forces, on that edge: state IDLE, ca = 0, cdo = 0, all strobes 1, rsp_valid = 0, rsp_rdata = 0.
REQ-035 rin asserted mid-cycle aborts the bus cycle, deasserts strobes on that edge and issues no rsp_valid.
REQ-036 cmd_valid is not accepted while rin = 1.

Configuration
REQ-037 Macro Z80IF_HALT_EN.
- Defined: an accepted halt command enters HALT with hlt_n low and ca[15:8] = cmd_addr[15:8], ca[7:0] = 0.
- In HALT, wake = 1 leaves to IDLE with hlt_n high and rsp_valid pulsed.
- wake is ignored in every other state.
REQ-038 Macro Z80IF_HALT_EN undefined: hlt_n is constant 1, HALT does not exist, and an accepted halt command pulses rsp_valid on the next cycle with rsp_rdata unchanged.

Verification
REQ-039 Mem read, addr 16'h4123, MEM_WAIT = 0, cdi = 8'h5A at T3 -> mrq_n and crd_n low for 2 cycles; rsp_valid 4 cycles after accept; rsp_rdata = 8'h5A.
REQ-040 I/O write, addr 16'h00D1, wdata 8'h21, IO_WAIT = 1 -> ior_n low 3 cycles; crd_n low; cdo = 8'h21; rsp_valid 5 cycles after accept.
REQ-041 Two mem writes (16'h2000/8'h11, then 16'h2001/8'h22), cmd_valid held high -> second T1 follows the first rsp_valid cycle; mrq_n high exactly 2 cycles between strobes.
REQ-042 I/O read 16'hB5, rin pulsed during TW -> strobes high on the next edge; no rsp_valid; cmd_ready = 1 after rin drops.
REQ-043 Z80IF_HALT_EN defined, halt with addr 16'h3F00, wake after 10 cycles -> hlt_n low 10 cycles; ca = 16'h3F00; rsp_valid one cycle after wake.
REQ-044 M1 read, addr 16'h0000, cdi = 8'hC3 -> cm1_n low T1-T3; rsp_rdata = 8'hC3.

Source files
------------

// File: rtl/z80_bus_initiator.sv
// Z80-style bus cycle initiator: turns a valid/ready command into a T1/T2/TW/T3 strobe sequence.
// Optional macro Z80IF_HALT_EN adds a HALT state exited by wake.
module z80_bus_initiator #(
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1
) (
    input  logic        mck,
    input  logic        rin,
    // Handshake: a command transfers on a posedge where cmd_valid & cmd_ready.
    // cmd_ready is high only in IDLE and never while rin is high.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_io,
    input  logic        cmd_wr,
    input  logic        cmd_m1,
    input  logic        cmd_halt,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    input  logic        wake,
    output logic [15:0] ca,
    output logic [7:0]  cdo,
    input  logic [7:0]  cdi,
    output logic        mrq_n,
    output logic        ior_n,
    output logic        crd_n,
    output logic        cm1_n,
    output logic        hlt_n,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_TW   = 3'd3,
        S_T3   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [2:0] MEM_W = 3'(MEM_WAIT);
    localparam logic [2:0] IO_W  = 3'(IO_WAIT);

    state_t      r_state;
    state_t      r_next;
    logic [15:0] r_ca;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic [2:0]  r_wait;
    logic        r_io;
    logic        r_wr;
    logic        r_m1;
    logic        r_rsp_valid;

    logic        w_accept;
    logic        w_bus;
    logic        w_act;
    logic [2:0]  w_wait_load;

    assign cmd_ready   = (r_state == S_IDLE) && !rin;
    assign w_accept    = cmd_ready && cmd_valid;
    assign w_wait_load = r_io ? IO_W : MEM_W;

    always_ff @(posedge mck) begin
        if (rin) r_state <= S_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_halt) begin
`ifdef Z80IF_HALT_EN
                        r_next = S_HALT;
`else
                        r_next = S_IDLE;
`endif
                    end else begin
                        r_next = S_T1;
                    end
                end
            end
            S_T1:   r_next = S_T2;
            S_T2:   r_next = (w_wait_load == 3'd0) ? S_T3 : S_TW;
            S_TW:   r_next = (r_wait == 3'd1) ? S_T3 : S_TW;
            S_T3:   r_next = S_IDLE;
            S_HALT: if (wake) r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mck) begin
        if (rin) begin
            r_ca        <= 16'h0000;
            r_wdata     <= 8'h00;
            r_rdata     <= 8'h00;
            r_wait      <= 3'd0;
            r_io        <= 1'b0;
            r_wr        <= 1'b0;
            r_m1        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (cmd_halt) begin
`ifdef Z80IF_HALT_EN
                            r_ca <= {cmd_addr[15:8], 8'h00};
`else
                            r_rsp_valid <= 1'b1;
`endif
                        end else begin
                            r_ca    <= cmd_addr;
                            r_io    <= cmd_io;
                            r_wr    <= cmd_wr;
                            r_m1    <= cmd_m1 && !cmd_io && !cmd_wr;
                            r_wdata <= cmd_wdata;
                        end
                    end
                end
                S_T2: r_wait <= w_wait_load;
                S_TW: r_wait <= r_wait - 3'd1;
                S_T3: begin
                    r_rsp_valid <= 1'b1;
                    if (!r_wr) r_rdata <= cdi;
                end
                S_HALT: if (wake) r_rsp_valid <= 1'b1;
                default: ;
            endcase
        end
    end

    // Strobes decode straight from state so a reset edge releases them immediately.
    assign w_bus = (r_state == S_T2) || (r_state == S_TW) || (r_state == S_T3);
    assign w_act = w_bus || (r_state == S_T1);

    assign mrq_n = !(w_bus && !r_io);
    assign ior_n = !(w_bus && r_io);
    assign crd_n = w_bus ? (r_io ^ r_wr) : 1'b1;
    assign cm1_n = !(w_act && r_m1);
    assign cdo   = (w_act && r_wr) ? r_wdata : 8'h00;
`ifdef Z80IF_HALT_EN
    assign hlt_n = (r_state != S_HALT);
`else
    assign hlt_n = 1'b1;
`endif

    assign ca          = r_ca;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign o_dbg_state = r_state;

endmodule
